// File: rtl/memory_controller_pkg.sv
// Shared definitions for the memory controller: FSM states, requester ids
// and the line-offset helper used to align addresses to cache lines.
package memory_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   typedef enum logic {
      PORT_ICACHE = 1'b0,
      PORT_DCACHE = 1'b1
   } port_t;

   localparam int DEFAULT_CACHE_LINE_SIZE = 128;

   function automatic int line_offset_bits(input int line_size);
      return $clog2(line_size / 8);
   endfunction

   localparam int LINE_OFFSET_BITS = line_offset_bits(DEFAULT_CACHE_LINE_SIZE);

endpackage

// File: rtl/mem_round_robin_arbiter.sv
// Two-requester round-robin arbiter: on a tie the port that did not win
// last time is granted. Grant is one-hot, bit 0 = icache, bit 1 = dcache.
module mem_round_robin_arbiter
   import memory_controller_pkg::*;
(
   input  logic       icache_valid,
   input  logic       dcache_valid,
   input  port_t      last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (icache_valid && (!dcache_valid || last_grant == PORT_DCACHE)) begin
         grant[0] = 1'b1;
      end else if (dcache_valid) begin
         grant[1] = 1'b1;
      end
   end

endmodule

// File: rtl/memory_controller.sv
// Single-outstanding memory controller between the I/D caches and Memory,
// emulating a fixed main-memory latency before a one-cycle memory access.
module memory_controller
   import memory_controller_pkg::*;
#(
   parameter int MEMORY_LOCATIONS = 4096,
   parameter int ADDRESS_SIZE     = 12,
   parameter int CACHE_LINE_SIZE  = 128,
   parameter int MEM_LATENCY      = 5
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       icache_req_valid,
   input  logic [ADDRESS_SIZE-1:0]    icache_req_address,
   output logic                       icache_req_ready,
   output logic                       icache_resp_valid,
   input  logic                       dcache_req_valid,
   input  logic                       dcache_req_write,
   input  logic [ADDRESS_SIZE-1:0]    dcache_req_address,
   input  logic [CACHE_LINE_SIZE-1:0] dcache_req_data,
   output logic                       dcache_req_ready,
   output logic                       dcache_resp_valid,
   output logic [CACHE_LINE_SIZE-1:0] resp_data,
   output logic                       mem_read_enable,
   output logic                       mem_write_enable,
   output logic [ADDRESS_SIZE-1:0]    mem_address,
   output logic [CACHE_LINE_SIZE-1:0] mem_data_in,
   input  logic [CACHE_LINE_SIZE-1:0] mem_data_out
);

   localparam int OFFSET_BITS = line_offset_bits(CACHE_LINE_SIZE);
   localparam int CNT_W       = $clog2(MEM_LATENCY + 1);

   if (MEM_LATENCY < 1 || (1 << ADDRESS_SIZE) != MEMORY_LOCATIONS) begin : g_bad_params
      $error("memory_controller: inconsistent MEM_LATENCY / ADDRESS_SIZE / MEMORY_LOCATIONS");
   end

   state_t                     state;
   port_t                      last_grant;
   port_t                      cur_port;
   logic                       cur_write;
   logic [CNT_W-1:0]           count;
   logic [1:0]                 grant;
   logic [CACHE_LINE_SIZE-1:0] resp_line_q;
   logic [ADDRESS_SIZE-1:0]    aligned_address;
   logic                       accept_icache;
   logic                       accept_dcache;

   mem_round_robin_arbiter u_arbiter (
      .icache_valid (icache_req_valid),
      .dcache_valid (dcache_req_valid),
      .last_grant   (last_grant),
      .grant        (grant)
   );

   assign icache_req_ready = rst_n && (state == ST_IDLE) && grant[0];
   assign dcache_req_ready = rst_n && (state == ST_IDLE) && grant[1];
   assign accept_icache    = icache_req_valid && icache_req_ready;
   assign accept_dcache    = dcache_req_valid && dcache_req_ready;

   always_comb begin
      aligned_address = grant[1] ? dcache_req_address : icache_req_address;
      aligned_address[OFFSET_BITS-1:0] = '0;
   end

   // Memory reads are synchronous, so the line only appears during RESP;
   // it is forwarded then and held in resp_line_q from then on.
   assign resp_data = (state == ST_RESP && !cur_write) ? mem_data_out : resp_line_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= ST_IDLE;
         last_grant        <= PORT_DCACHE;
         cur_port          <= PORT_ICACHE;
         cur_write         <= 1'b0;
         count             <= '0;
         resp_line_q       <= '0;
         mem_read_enable   <= 1'b0;
         mem_write_enable  <= 1'b0;
         mem_address       <= '0;
         mem_data_in       <= '0;
         icache_resp_valid <= 1'b0;
         dcache_resp_valid <= 1'b0;
      end else begin
         mem_read_enable   <= 1'b0;
         mem_write_enable  <= 1'b0;
         icache_resp_valid <= 1'b0;
         dcache_resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept_icache || accept_dcache) begin
                  cur_port    <= accept_dcache ? PORT_DCACHE : PORT_ICACHE;
                  last_grant  <= accept_dcache ? PORT_DCACHE : PORT_ICACHE;
                  cur_write   <= accept_dcache && dcache_req_write;
                  mem_address <= aligned_address;
                  if (accept_dcache) begin
                     mem_data_in <= dcache_req_data;
                  end
                  count <= CNT_W'(MEM_LATENCY - 1);
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (count == '0) begin
                  mem_read_enable  <= !cur_write;
                  mem_write_enable <= cur_write;
                  state            <= ST_ACCESS;
               end else begin
                  count <= count - CNT_W'(1);
               end
            end
            ST_ACCESS: begin
               icache_resp_valid <= (cur_port == PORT_ICACHE);
               dcache_resp_valid <= (cur_port == PORT_DCACHE);
               state             <= ST_RESP;
            end
            ST_RESP: begin
               if (!cur_write) begin
                  resp_line_q <= mem_data_out;
               end
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_controller.sv
// Self-checking bench for memory_controller: a synchronous Memory model,
// a timeline-based reference model checked every cycle, and directed tests.
module tb_memory_controller;
   import memory_controller_pkg::*;

   localparam int MEMORY_LOCATIONS = 4096;
   localparam int ADDRESS_SIZE     = 12;
   localparam int CACHE_LINE_SIZE  = 128;
   localparam int MEM_LATENCY      = 5;
   localparam int LINES            = 256;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         icache_req_valid = 1'b0;
   logic [11:0]  icache_req_address = '0;
   logic         icache_req_ready;
   logic         icache_resp_valid;
   logic         dcache_req_valid = 1'b0;
   logic         dcache_req_write = 1'b0;
   logic [11:0]  dcache_req_address = '0;
   logic [127:0] dcache_req_data = '0;
   logic         dcache_req_ready;
   logic         dcache_resp_valid;
   logic [127:0] resp_data;
   logic         mem_read_enable;
   logic         mem_write_enable;
   logic [11:0]  mem_address;
   logic [127:0] mem_data_in;
   logic [127:0] mem_data_out = '0;

   memory_controller #(
      .MEMORY_LOCATIONS (MEMORY_LOCATIONS),
      .ADDRESS_SIZE     (ADDRESS_SIZE),
      .CACHE_LINE_SIZE  (CACHE_LINE_SIZE),
      .MEM_LATENCY      (MEM_LATENCY)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .icache_req_valid   (icache_req_valid),
      .icache_req_address (icache_req_address),
      .icache_req_ready   (icache_req_ready),
      .icache_resp_valid  (icache_resp_valid),
      .dcache_req_valid   (dcache_req_valid),
      .dcache_req_write   (dcache_req_write),
      .dcache_req_address (dcache_req_address),
      .dcache_req_data    (dcache_req_data),
      .dcache_req_ready   (dcache_req_ready),
      .dcache_resp_valid  (dcache_resp_valid),
      .resp_data          (resp_data),
      .mem_read_enable    (mem_read_enable),
      .mem_write_enable   (mem_write_enable),
      .mem_address        (mem_address),
      .mem_data_in        (mem_data_in),
      .mem_data_out       (mem_data_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory block: synchronous read and write on the enable edge.
   logic [127:0] bench_mem [LINES];
   always @(posedge clk) begin
      if (mem_write_enable) bench_mem[mem_address[11:4]] <= mem_data_in;
      if (mem_read_enable)  mem_data_out <= bench_mem[mem_address[11:4]];
   end

   int n_compared = 0;
   int n_mismatched = 0;

   task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Reference model: transaction timeline relative to the acceptance cycle.
   logic [127:0] ref_mem [LINES];
   bit           m_busy = 1'b0;
   int           m_acc = 0;
   port_t        m_port = PORT_ICACHE;
   port_t        m_last = PORT_DCACHE;
   bit           m_wr = 1'b0;
   logic [11:0]  m_addr = '0;
   logic [127:0] m_wdata = '0;
   logic [127:0] m_line = '0;
   logic [127:0] m_resp = '0;

   always @(negedge clk) begin
      bit idle, gi, gd, e_rd, e_wr, e_resp;
      if (!rst_n) begin
         check_output("reset_flags", {icache_req_ready, dcache_req_ready, icache_resp_valid,
                      dcache_resp_valid, mem_read_enable, mem_write_enable}, 128'd0);
         check_output("reset_resp_data", resp_data, 128'd0);
         check_output("reset_mem_address", mem_address, 128'd0);
         check_output("reset_mem_data_in", mem_data_in, 128'd0);
         m_busy  = 1'b0;
         m_last  = PORT_DCACHE;
         m_addr  = '0;
         m_wdata = '0;
         m_resp  = '0;
      end else begin
         idle   = !m_busy;
         gi     = icache_req_valid && (!dcache_req_valid || m_last == PORT_DCACHE);
         gd     = dcache_req_valid && !gi;
         e_rd   = m_busy && (cyc == m_acc + MEM_LATENCY + 1) && !m_wr;
         e_wr   = m_busy && (cyc == m_acc + MEM_LATENCY + 1) && m_wr;
         e_resp = m_busy && (cyc == m_acc + MEM_LATENCY + 2);
         if (e_resp && !m_wr) m_resp = m_line;
         check_output("icache_req_ready", icache_req_ready, idle && gi);
         check_output("dcache_req_ready", dcache_req_ready, idle && gd);
         check_output("mem_read_enable", mem_read_enable, e_rd);
         check_output("mem_write_enable", mem_write_enable, e_wr);
         check_output("icache_resp_valid", icache_resp_valid, e_resp && m_port == PORT_ICACHE);
         check_output("dcache_resp_valid", dcache_resp_valid, e_resp && m_port == PORT_DCACHE);
         check_output("resp_data", resp_data, m_resp);
         check_output("mem_address", mem_address, m_addr);
         check_output("mem_data_in", mem_data_in, m_wdata);
         if (e_rd) m_line = ref_mem[m_addr[11:4]];
         if (e_wr) ref_mem[m_addr[11:4]] = m_wdata;
         if (e_resp) m_busy = 1'b0;
         if (idle && (gi || gd)) begin
            m_busy = 1'b1;
            m_acc  = cyc;
            m_port = gd ? PORT_DCACHE : PORT_ICACHE;
            m_last = m_port;
            m_wr   = gd && dcache_req_write;
            m_addr = {(gd ? dcache_req_address[11:4] : icache_req_address[11:4]), 4'h0};
            if (gd) m_wdata = dcache_req_data;
         end
      end
   end

   // Event monitor used by the directed tests.
   int          rd_pulses = 0;
   int          wr_pulses = 0;
   int          iresp_count = 0;
   int          dresp_count = 0;
   logic [11:0] last_access_addr = '0;
   int          acc_cycles [$];
   port_t       acc_ports [$];

   always @(negedge clk) begin
      if (mem_read_enable) rd_pulses++;
      if (mem_write_enable) wr_pulses++;
      if (mem_read_enable || mem_write_enable) last_access_addr = mem_address;
      if (icache_resp_valid) iresp_count++;
      if (dcache_resp_valid) dresp_count++;
      if (icache_req_valid && icache_req_ready) begin
         acc_cycles.push_back(cyc);
         acc_ports.push_back(PORT_ICACHE);
      end
      if (dcache_req_valid && dcache_req_ready) begin
         acc_cycles.push_back(cyc);
         acc_ports.push_back(PORT_DCACHE);
      end
   end

   task automatic apply_stimulus(input port_t port, input logic wr, input logic [11:0] addr,
                                 input logic [127:0] data, output int acc_cyc);
      acc_cyc = -1;
      @(posedge clk); #1;
      if (port == PORT_ICACHE) begin
         icache_req_valid   = 1'b1;
         icache_req_address = addr;
      end else begin
         dcache_req_valid   = 1'b1;
         dcache_req_write   = wr;
         dcache_req_address = addr;
         dcache_req_data    = data;
      end
      for (int i = 0; i < 40; i++) begin
         #1;
         if (port == PORT_ICACHE ? icache_req_ready : dcache_req_ready) begin
            acc_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      icache_req_valid = 1'b0;
      dcache_req_valid = 1'b0;
      if (acc_cyc < 0) check_output("accept_timeout", 128'd0, 128'd1);
   endtask

   task automatic wait_resp(input port_t port, output int resp_cyc, output logic [127:0] line);
      resp_cyc = -1;
      line = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((port == PORT_ICACHE && icache_resp_valid) || (port == PORT_DCACHE && dcache_resp_valid)) begin
            resp_cyc = cyc;
            line = resp_data;
            break;
         end
      end
      if (resp_cyc < 0) check_output("resp_timeout", 128'd0, 128'd1);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int acc, rc, base_rd, base_wr, snap_i, snap_d, snap_w;
      logic [127:0] line;
      logic [127:0] v;

      for (int i = 0; i < LINES; i++) begin
         v = {$urandom, $urandom, $urandom, $urandom};
         bench_mem[i] = v;
         ref_mem[i]   = v;
      end
      bench_mem[0] = 128'h00FF00FF_00FF00FF_00FF00FF_00FF00FF;
      ref_mem[0]   = 128'h00FF00FF_00FF00FF_00FF00FF_00FF00FF;
      bench_mem[2] = 128'h55AA55AA_11223344_55667788_99AABBCC;
      ref_mem[2]   = 128'h55AA55AA_11223344_55667788_99AABBCC;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_output("por_mem_address", mem_address, 128'd0);
      check_output("por_resp_data", resp_data, 128'd0);
      rst_n = 1'b1;

      $display("[TB] single icache read at 0x000");
      base_rd = rd_pulses;
      @(posedge clk); #1;
      icache_req_valid   = 1'b1;
      icache_req_address = 12'h000;
      #1;
      check_output("t1_ready_same_cycle", icache_req_ready, 128'd1);
      acc = cyc;
      @(posedge clk); #1;
      icache_req_valid = 1'b0;
      wait_resp(PORT_ICACHE, rc, line);
      @(posedge clk); #1;
      check_output("t1_read_enable_offset", 128'(acc_last_rd_offset(acc)), 128'd6);
      check_output("t1_read_enable_pulses", 128'(rd_pulses - base_rd), 128'd1);
      check_output("t1_resp_offset", 128'(rc - acc), 128'd7);
      check_output("t1_resp_line", line, 128'h00FF00FF_00FF00FF_00FF00FF_00FF00FF);

      $display("[TB] dcache write then read at 0x010");
      base_wr = wr_pulses;
      apply_stimulus(PORT_DCACHE, 1'b1, 12'h010, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, acc);
      wait_resp(PORT_DCACHE, rc, line);
      @(posedge clk); #1;
      check_output("t2_write_ack_offset", 128'(rc - acc), 128'd7);
      check_output("t2_write_enable_pulses", 128'(wr_pulses - base_wr), 128'd1);
      apply_stimulus(PORT_DCACHE, 1'b0, 12'h010, 128'd0, acc);
      wait_resp(PORT_DCACHE, rc, line);
      check_output("t2_read_back", line, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);

      $display("[TB] unaligned address 0x01B");
      apply_stimulus(PORT_DCACHE, 1'b0, 12'h01B, 128'd0, acc);
      wait_resp(PORT_DCACHE, rc, line);
      check_output("t3_aligned_address", last_access_addr, 128'h010);
      check_output("t3_unaligned_line", line, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);

      $display("[TB] tie arbitration after reset");
      pulse_reset();
      acc_cycles.delete();
      acc_ports.delete();
      @(posedge clk); #1;
      icache_req_valid   = 1'b1;
      icache_req_address = 12'h040;
      dcache_req_valid   = 1'b1;
      dcache_req_write   = 1'b0;
      dcache_req_address = 12'h030;
      for (int i = 0; i < 60 && acc_cycles.size() < 3; i++) @(posedge clk);
      #1;
      icache_req_valid = 1'b0;
      dcache_req_valid = 1'b0;
      if (acc_cycles.size() < 3) begin
         check_output("t4_accept_timeout", 128'(acc_cycles.size()), 128'd3);
      end else begin
         check_output("t4_first_grant", acc_ports[0], PORT_ICACHE);
         check_output("t4_second_grant", acc_ports[1], PORT_DCACHE);
         check_output("t4_third_grant", acc_ports[2], PORT_ICACHE);
         check_output("t4_spacing_1", 128'(acc_cycles[1] - acc_cycles[0]), 128'd8);
         check_output("t4_spacing_2", 128'(acc_cycles[2] - acc_cycles[1]), 128'd8);
      end
      wait_resp(PORT_ICACHE, rc, line);

      $display("[TB] reset asserted mid-WAIT");
      apply_stimulus(PORT_DCACHE, 1'b1, 12'h020, 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0, acc);
      snap_i = iresp_count;
      snap_d = dresp_count;
      snap_w = wr_pulses;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check_output("t5_async_flags", {icache_req_ready, dcache_req_ready, icache_resp_valid,
                   dcache_resp_valid, mem_read_enable, mem_write_enable}, 128'd0);
      check_output("t5_async_mem_address", mem_address, 128'd0);
      check_output("t5_async_mem_data_in", mem_data_in, 128'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check_output("t5_no_dropped_resp", 128'((iresp_count - snap_i) + (dresp_count - snap_d)), 128'd0);
      check_output("t5_no_dropped_write", 128'(wr_pulses - snap_w), 128'd0);
      apply_stimulus(PORT_DCACHE, 1'b0, 12'h020, 128'd0, acc);
      wait_resp(PORT_DCACHE, rc, line);
      check_output("t5_next_resp_offset", 128'(rc - acc), 128'd7);
      check_output("t5_line_untouched", line, 128'h55AA55AA_11223344_55667788_99AABBCC);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         icache_req_valid   = ($urandom_range(0, 1) == 1);
         icache_req_address = 12'($urandom_range(0, 255));
         dcache_req_valid   = ($urandom_range(0, 1) == 1);
         dcache_req_write   = ($urandom_range(0, 1) == 1);
         dcache_req_address = 12'($urandom_range(0, 255));
         dcache_req_data    = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
      icache_req_valid = 1'b0;
      dcache_req_valid = 1'b0;
      repeat (15) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   // Most recent read-enable cycle relative to an acceptance cycle.
   int last_rd_cyc = -1;
   always @(negedge clk) if (mem_read_enable) last_rd_cyc = cyc;

   function automatic int acc_last_rd_offset(input int acc_cyc);
      return last_rd_cyc - acc_cyc;
   endfunction

endmodule
